// File: rtl/ccpu_bus_if.sv
// Memory-side strobes and address of the ccpu_core SRAM port.
// The bidirectional data bus stays a plain inout on the core.
interface ccpu_bus_if;
  logic [15:0] a;
  logic        n_oe;
  logic        n_we;
  logic        n_rdy;

  modport master (output a, output n_oe, output n_we, input n_rdy);
  modport slave  (input a, input n_oe, input n_we, output n_rdy);
endinterface

// File: rtl/ccpu_core.sv
// Minimal 8-bit accumulator CPU driving an asynchronous SRAM, one bus access per clock.
// state | meaning
// FETCH | read opcode at PC; register-only ops execute on this edge
// OPLO  | read low operand byte (or imm8)
// OPHI  | read high operand byte; jumps resolve here
// MRD   | read data at {hi,lo} into A
// WR1   | drive A at {hi,lo}, n_we low
// WR2   | n_we high with address/data held, memory latches
module ccpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  ccpu_bus_if.master bus,
  inout  wire  [7:0] d
);

  localparam logic [7:0] OP_LDI_A = 8'h01;
  localparam logic [7:0] OP_LDI_B = 8'h02;
  localparam logic [7:0] OP_LD    = 8'h03;
  localparam logic [7:0] OP_ST    = 8'h04;
  localparam logic [7:0] OP_MOV   = 8'h05;
  localparam logic [7:0] OP_ADD   = 8'h06;
  localparam logic [7:0] OP_SUB   = 8'h07;
  localparam logic [7:0] OP_AND   = 8'h08;
  localparam logic [7:0] OP_OR    = 8'h09;
  localparam logic [7:0] OP_XOR   = 8'h0A;
  localparam logic [7:0] OP_JMP   = 8'h0B;
  localparam logic [7:0] OP_JZ    = 8'h0C;
  localparam logic [7:0] OP_JNZ   = 8'h0D;
  localparam logic [7:0] OP_JC    = 8'h0E;
  localparam logic [7:0] OP_JNC   = 8'h0F;

  typedef enum logic [2:0] {S_FETCH, S_OPLO, S_OPHI, S_MRD, S_WR1, S_WR2} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [7:0]  reg_a, reg_a_nxt, reg_b, reg_b_nxt;
  logic        flag_z, flag_z_nxt, flag_c, flag_c_nxt;
  logic [7:0]  op_lo, op_lo_nxt, op_hi, op_hi_nxt, opcode, opcode_nxt;
  logic [15:0] a_q, a_nxt;
  logic        n_oe_q, n_oe_nxt, n_we_q, n_we_nxt;
  logic        d_drv, d_drv_nxt;
  logic [7:0]  d_out, d_out_nxt;
  logic [8:0]  alu;
  logic        alu_op;
  logic        jump_taken;

  // n_rdy high freezes every register, including the bus strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      reg_a  <= 8'h00;
      reg_b  <= 8'h00;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      op_lo  <= 8'h00;
      op_hi  <= 8'h00;
      opcode <= 8'h00;
      a_q    <= RESET_PC;
      n_oe_q <= 1'b0;
      n_we_q <= 1'b1;
      d_drv  <= 1'b0;
      d_out  <= 8'h00;
    end else if (!bus.n_rdy) begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      reg_a  <= reg_a_nxt;
      reg_b  <= reg_b_nxt;
      flag_z <= flag_z_nxt;
      flag_c <= flag_c_nxt;
      op_lo  <= op_lo_nxt;
      op_hi  <= op_hi_nxt;
      opcode <= opcode_nxt;
      a_q    <= a_nxt;
      n_oe_q <= n_oe_nxt;
      n_we_q <= n_we_nxt;
      d_drv  <= d_drv_nxt;
      d_out  <= d_out_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        case (d)
          OP_LDI_A, OP_LDI_B, OP_LD, OP_ST,
          OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: state_nxt = S_OPLO;
          default:                              state_nxt = S_FETCH;
        endcase
      end
      S_OPLO:  state_nxt = (opcode == OP_LDI_A || opcode == OP_LDI_B) ? S_FETCH : S_OPHI;
      S_OPHI: begin
        if (opcode == OP_LD)      state_nxt = S_MRD;
        else if (opcode == OP_ST) state_nxt = S_WR1;
        else                      state_nxt = S_FETCH;
      end
      S_WR1:   state_nxt = S_WR2;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_nxt     = pc;
    reg_a_nxt  = reg_a;
    reg_b_nxt  = reg_b;
    flag_z_nxt = flag_z;
    flag_c_nxt = flag_c;
    op_lo_nxt  = op_lo;
    op_hi_nxt  = op_hi;
    opcode_nxt = opcode;
    alu        = 9'd0;
    alu_op     = 1'b0;
    jump_taken = 1'b0;

    case (state)
      S_FETCH: begin
        opcode_nxt = d;
        pc_nxt     = pc + 16'd1;
        case (d)
          OP_MOV: reg_b_nxt = reg_a;
          OP_ADD: begin alu = {1'b0, reg_a} + {1'b0, reg_b}; alu_op = 1'b1; end
          OP_SUB: begin alu = {1'b0, reg_a} - {1'b0, reg_b}; alu_op = 1'b1; end
          OP_AND: begin alu = {1'b0, reg_a & reg_b};         alu_op = 1'b1; end
          OP_OR:  begin alu = {1'b0, reg_a | reg_b};         alu_op = 1'b1; end
          OP_XOR: begin alu = {1'b0, reg_a ^ reg_b};         alu_op = 1'b1; end
          default: ;
        endcase
        if (alu_op) begin
          reg_a_nxt  = alu[7:0];
          flag_c_nxt = alu[8];
          flag_z_nxt = (alu[7:0] == 8'h00);
        end
      end
      S_OPLO: begin
        op_lo_nxt = d;
        pc_nxt    = pc + 16'd1;
        if (opcode == OP_LDI_A) begin
          reg_a_nxt  = d;
          flag_z_nxt = (d == 8'h00);
        end else if (opcode == OP_LDI_B) begin
          reg_b_nxt = d;
        end
      end
      S_OPHI: begin
        op_hi_nxt = d;
        case (opcode)
          OP_JMP:  jump_taken = 1'b1;
          OP_JZ:   jump_taken = flag_z;
          OP_JNZ:  jump_taken = !flag_z;
          OP_JC:   jump_taken = flag_c;
          OP_JNC:  jump_taken = !flag_c;
          default: jump_taken = 1'b0;
        endcase
        pc_nxt = jump_taken ? {d, op_lo} : pc + 16'd1;
      end
      S_MRD: begin
        reg_a_nxt  = d;
        flag_z_nxt = (d == 8'h00);
      end
      default: ;
    endcase
  end

  // Bus outputs are registered from the state being entered.
  always_comb begin
    a_nxt     = pc_nxt;
    n_oe_nxt  = 1'b0;
    n_we_nxt  = 1'b1;
    d_drv_nxt = 1'b0;
    d_out_nxt = d_out;
    case (state_nxt)
      S_MRD: a_nxt = {op_hi_nxt, op_lo_nxt};
      S_WR1: begin
        a_nxt     = {op_hi_nxt, op_lo_nxt};
        n_oe_nxt  = 1'b1;
        n_we_nxt  = 1'b0;
        d_drv_nxt = 1'b1;
        d_out_nxt = reg_a;
      end
      S_WR2: begin
        a_nxt     = {op_hi_nxt, op_lo_nxt};
        n_oe_nxt  = 1'b1;
        d_drv_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.a    = a_q;
  assign bus.n_oe = n_oe_q;
  assign bus.n_we = n_we_q;
  assign d        = d_drv ? d_out : 8'bz;

endmodule

// File: tb/tb_ccpu_core.sv
// Directed bench for ccpu_core: async SRAM model plus short hand-assembled programs.
module tb_ccpu_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [7:0] d;
  logic [7:0] mem [0:65535];
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;

  ccpu_bus_if bus ();

  ccpu_core #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .d   (d)
  );

  always #5 clk = ~clk;

  assign d = (!bus.n_oe && bus.n_we) ? mem[bus.a] : 8'bz;

  // SRAM latches on the rising edge of n_we; edges caused by reset are not writes.
  always @(posedge bus.n_we) begin
    if (!rst) begin
      mem[bus.a] = d;
      wr_cnt++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_cpu();
    rst = 1'b1;
    bus.n_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input logic [15:0] target, input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.a == target && !bus.n_oe && bus.n_we) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 8'hC3;
    mem[1] = 8'hC3;
    rst = 1'b1;
    bus.n_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.a !== 16'h0000) begin errors++; $display("FAIL reset_a got %h exp 0000", bus.a); end
    checks++; if (bus.n_oe !== 1'b0) begin errors++; $display("FAIL reset_n_oe got %b exp 0", bus.n_oe); end
    checks++; if (bus.n_we !== 1'b1) begin errors++; $display("FAIL reset_n_we got %b exp 1", bus.n_we); end
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL reset_d_released got %h exp C3", d); end
    rst = 1'b0;
    #1;
    checks++; if (bus.a !== 16'h0000) begin errors++; $display("FAIL first_fetch_a got %h exp 0000", bus.a); end
    @(negedge clk);
    checks++; if (bus.a !== 16'h0001 || bus.n_oe !== 1'b0) begin errors++; $display("FAIL second_fetch got a=%h n_oe=%b exp 0001/0", bus.a, bus.n_oe); end
    @(negedge clk);
    checks++; if (bus.a !== 16'h0002) begin errors++; $display("FAIL third_fetch_a got %h exp 0002", bus.a); end
  endtask

  task automatic test_add_store();
    int low_cnt, fetch_cyc, wr0;
    bit prev_low;
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h01, 8'h05, 8'h05, 8'h01, 8'h07, 8'h06};
    {mem[6], mem[7], mem[8]}  = {8'h04, 8'h00, 8'h01};
    {mem[9], mem[10], mem[11]} = {8'h0B, 8'h00, 8'h10};
    wr0 = wr_cnt;
    low_cnt = 0; fetch_cyc = 0; prev_low = 1'b0;
    reset_cpu();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!bus.n_we) begin
        low_cnt++;
        prev_low = 1'b1;
        checks++; if (bus.a !== 16'h0100 || d !== 8'h0C || bus.n_oe !== 1'b1) begin errors++; $display("FAIL st_wr1 got a=%h d=%h n_oe=%b exp 0100/0C/1", bus.a, d, bus.n_oe); end
      end else if (prev_low) begin
        prev_low = 1'b0;
        checks++; if (bus.a !== 16'h0100 || d !== 8'h0C) begin errors++; $display("FAIL st_wr2_hold got a=%h d=%h exp 0100/0C", bus.a, d); end
      end
      if (fetch_cyc == 0 && bus.a == 16'h1000 && !bus.n_oe) fetch_cyc = i;
    end
    checks++; if (low_cnt !== 1) begin errors++; $display("FAIL st_pulse_len got %0d exp 1", low_cnt); end
    checks++; if (fetch_cyc == 0 || fetch_cyc > 16) begin errors++; $display("FAIL finish_fetch_1000 got cycle %0d exp 1..16", fetch_cyc); end
    checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL add_write_count got %0d exp 1", wr_cnt - wr0); end
    checks++; if (mem[16'h0100] !== 8'h0C) begin errors++; $display("FAIL add_result got %h exp 0C", mem[16'h0100]); end
  endtask

  task automatic test_flags();
    bit seen_2000, seen_2100, seen_2107, seen_3000;
    int done;
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h01, 8'hFF, 8'h02, 8'h01, 8'h06};
    {mem[5], mem[6], mem[7]} = {8'h0E, 8'h00, 8'h20};
    {mem[16'h2000], mem[16'h2001], mem[16'h2002]} = {8'h0C, 8'h00, 8'h21};
    {mem[16'h2100], mem[16'h2101], mem[16'h2102], mem[16'h2103]} = {8'h04, 8'h00, 8'h03, 8'h07};
    {mem[16'h2104], mem[16'h2105], mem[16'h2106]} = {8'h0C, 8'h00, 8'h30};
    {mem[16'h2107], mem[16'h2108], mem[16'h2109]} = {8'h0E, 8'h00, 8'h40};
    {mem[16'h4000], mem[16'h4001], mem[16'h4002]} = {8'h04, 8'h01, 8'h03};
    {mem[16'h4003], mem[16'h4004], mem[16'h4005]} = {8'h0B, 8'h00, 8'h50};
    mem[16'h0300] = 8'h77;
    mem[16'h0301] = 8'h77;
    {seen_2000, seen_2100, seen_2107, seen_3000} = 4'b0000;
    done = 0;
    reset_cpu();
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!bus.n_oe && bus.a == 16'h2000) seen_2000 = 1'b1;
      if (!bus.n_oe && bus.a == 16'h2100) seen_2100 = 1'b1;
      if (!bus.n_oe && bus.a == 16'h2107) seen_2107 = 1'b1;
      if (!bus.n_oe && bus.a == 16'h3000) seen_3000 = 1'b1;
      if (!bus.n_oe && bus.a == 16'h5000) begin done = i; break; end
    end
    checks++; if (seen_2000 !== 1'b1) begin errors++; $display("FAIL jc_after_add_carry got taken=%b exp 1", seen_2000); end
    checks++; if (seen_2100 !== 1'b1) begin errors++; $display("FAIL jz_after_add_zero got taken=%b exp 1", seen_2100); end
    checks++; if (mem[16'h0300] !== 8'h00) begin errors++; $display("FAIL add_wrap_result got %h exp 00", mem[16'h0300]); end
    checks++; if (seen_3000 !== 1'b0) begin errors++; $display("FAIL jz_after_sub got taken=%b exp 0", seen_3000); end
    checks++; if (seen_2107 !== 1'b1) begin errors++; $display("FAIL jz_not_taken_pc got fetch2107=%b exp 1", seen_2107); end
    checks++; if (mem[16'h0301] !== 8'hFF) begin errors++; $display("FAIL sub_borrow_result got %h exp FF", mem[16'h0301]); end
    checks++; if (done == 0) begin errors++; $display("FAIL flags_finish got cycle %0d exp nonzero", done); end
  endtask

  task automatic test_load();
    int wr0, cyc;
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h03, 8'h00, 8'h02, 8'h04, 8'h01, 8'h01};
    {mem[6], mem[7], mem[8]} = {8'h03, 8'h01, 8'h02};
    {mem[9], mem[10], mem[11]} = {8'h0C, 8'h00, 8'h61};
    {mem[12], mem[13], mem[14]} = {8'h0B, 8'h00, 8'h60};
    mem[16'h0200] = 8'hA5;
    mem[16'h0201] = 8'h00;
    wr0 = wr_cnt;
    reset_cpu();
    repeat (3) @(negedge clk);
    checks++; if (bus.a !== 16'h0200 || bus.n_oe !== 1'b0 || bus.n_we !== 1'b1) begin errors++; $display("FAIL ld_read_cycle got a=%h n_oe=%b n_we=%b exp 0200/0/1", bus.a, bus.n_oe, bus.n_we); end
    wait_fetch(16'h6100, 30, cyc);
    checks++; if (cyc == 0) begin errors++; $display("FAIL ld_zero_sets_z got cycle %0d exp nonzero", cyc); end
    checks++; if (mem[16'h0101] !== 8'hA5) begin errors++; $display("FAIL ld_st_value got %h exp A5", mem[16'h0101]); end
    checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL ld_write_count got %0d exp 1", wr_cnt - wr0); end
  endtask

  task automatic test_stall();
    int wr0, cyc;
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h01, 8'h3C, 8'h04, 8'h00, 8'h07};
    {mem[5], mem[6], mem[7]} = {8'h0B, 8'h00, 8'h70};
    wr0 = wr_cnt;
    reset_cpu();
    bus.n_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.a !== 16'h0000 || bus.n_oe !== 1'b0) begin errors++; $display("FAIL stall_fetch_hold got a=%h n_oe=%b exp 0000/0", bus.a, bus.n_oe); end
    end
    bus.n_rdy = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!bus.n_we) begin cyc = i; break; end
    end
    checks++; if (cyc == 0) begin errors++; $display("FAIL stall_reach_wr1 got cycle %0d exp nonzero", cyc); end
    bus.n_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.a !== 16'h0700 || d !== 8'h3C || bus.n_oe !== 1'b1 || bus.n_we !== 1'b0) begin errors++; $display("FAIL stall_wr1_frozen got a=%h d=%h n_oe=%b n_we=%b exp 0700/3C/1/0", bus.a, d, bus.n_oe, bus.n_we); end
    end
    bus.n_rdy = 1'b0;
    @(negedge clk);
    checks++; if (bus.a !== 16'h0700 || d !== 8'h3C || bus.n_we !== 1'b1) begin errors++; $display("FAIL stall_wr2 got a=%h d=%h n_we=%b exp 0700/3C/1", bus.a, d, bus.n_we); end
    wait_fetch(16'h7000, 10, cyc);
    checks++; if (cyc == 0) begin errors++; $display("FAIL stall_finish got cycle %0d exp nonzero", cyc); end
    checks++; if (wr_cnt - wr0 !== 1 || mem[16'h0700] !== 8'h3C) begin errors++; $display("FAIL stall_single_write got count=%0d val=%h exp 1/3C", wr_cnt - wr0, mem[16'h0700]); end
  endtask

  task automatic test_reset_in_wr1();
    int wr0, cyc;
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h01, 8'h9A, 8'h05, 8'h04, 8'h00, 8'h08};
    mem[16'h0800] = 8'h11;
    wr0 = wr_cnt;
    reset_cpu();
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!bus.n_we) begin cyc = i; break; end
    end
    checks++; if (cyc == 0) begin errors++; $display("FAIL rstwr_reach_wr1 got cycle %0d exp nonzero", cyc); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.n_we !== 1'b1 || bus.n_oe !== 1'b0 || bus.a !== 16'h0000) begin errors++; $display("FAIL rstwr_bus got a=%h n_oe=%b n_we=%b exp 0000/0/1", bus.a, bus.n_oe, bus.n_we); end
    checks++; if (wr_cnt !== wr0 || mem[16'h0800] !== 8'h11) begin errors++; $display("FAIL rstwr_no_write got count=%0d val=%h exp 0/11", wr_cnt - wr0, mem[16'h0800]); end
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3]} = {8'h06, 8'h04, 8'h00, 8'h09};
    {mem[4], mem[5], mem[6]} = {8'h0B, 8'h00, 8'h0A};
    mem[16'h0900] = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    wait_fetch(16'h0A00, 20, cyc);
    checks++; if (cyc == 0) begin errors++; $display("FAIL rstwr_restart got cycle %0d exp nonzero", cyc); end
    checks++; if (mem[16'h0900] !== 8'h00 || wr_cnt - wr0 !== 1) begin errors++; $display("FAIL rstwr_regs_cleared got val=%h count=%0d exp 00/1", mem[16'h0900], wr_cnt - wr0); end
  endtask

  initial begin
    bus.n_rdy = 1'b0;
    test_reset();
    test_add_store();
    test_flags();
    test_load();
    test_stall();
    test_reset_in_wr1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
